// File: rtl/memory_endpoint_programmer.sv
// memory_endpoint_programmer
//   Host-side writer for the memory-endpoint table. Accepts one config
//   command at a time over a valid/ready channel and validates it. It then
//   updates the packed per-endpoint control vector and returns one response
//   per command.
//
//   Entry layout (99 bits): [47:0] base, [95:48] bound (inclusive),
//                           [97:96] access, [98] valid
//
//   Optional feature macro: EP_PROG_OVERLAP_CHECK_EN
//     When defined, a valid WRITE that passes the basic checks is compared
//     against every other valid slot, one slot per cycle. An overlapping
//     range is rejected with status OVERLAP.
//
// Ports
//   aclk, areset       clock, synchronous active-high reset
//   s_cmd_*            command channel (op, idx, base, bound, access, ep_valid)
//   m_rsp_*            response channel (status, resulting entry)
//   ep_ctrl            packed table, slot i at [i*99 +: 99]
//   ep_update          1-cycle pulse when a new table value first becomes visible
module memory_endpoint_programmer #(
  parameter int N_ENDPOINTS = 4,
  parameter int IDX_W       = (N_ENDPOINTS > 1) ? $clog2(N_ENDPOINTS) : 1
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      s_cmd_valid,
  output logic                      s_cmd_ready,
  input  logic [1:0]                s_cmd_op,
  input  logic [IDX_W-1:0]          s_cmd_idx,
  input  logic [47:0]               s_cmd_base,
  input  logic [47:0]               s_cmd_bound,
  input  logic [1:0]                s_cmd_access,
  input  logic                      s_cmd_ep_valid,
  output logic                      m_rsp_valid,
  input  logic                      m_rsp_ready,
  output logic [1:0]                m_rsp_status,
  output logic [98:0]               m_rsp_data,
  output logic [99*N_ENDPOINTS-1:0] ep_ctrl,
  output logic                      ep_update
);
  localparam int EP_W = 99;
  localparam int VBIT = 98;

  localparam logic [1:0] OP_WRITE   = 2'b00;
  localparam logic [1:0] OP_READ    = 2'b01;
  localparam logic [1:0] OP_INV     = 2'b10;
  localparam logic [1:0] OP_INV_ALL = 2'b11;

  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_BAD_IDX   = 2'b01;
  localparam logic [1:0] ST_BAD_RANGE = 2'b10;

`ifdef EP_PROG_OVERLAP_CHECK_EN
  localparam logic [1:0] ST_OVERLAP = 2'b11;
  localparam int         SJ_W       = (N_ENDPOINTS > 1) ? $clog2(N_ENDPOINTS) : 1;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SCAN, S_APPLY, S_RESP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_APPLY, S_RESP} state_t;
`endif

  state_t            r_state, w_state_next;
  logic [1:0]        r_op;
  logic [IDX_W-1:0]  r_idx;
  logic [47:0]       r_base, r_bound;
  logic [1:0]        r_access;
  logic              r_ep_valid;
  logic [1:0]        r_status;
  logic [EP_W-1:0]   r_rsp_data;
  logic              r_ep_update;
  logic [EP_W-1:0]   r_slot [N_ENDPOINTS];

  logic              w_in_range;
  logic [1:0]        w_chk_status;
  logic [EP_W-1:0]   w_old_entry, w_new_entry, w_after_entry;

  // Index decode done by comparison so an index wider than the table stays legal.
  always_comb begin
    w_in_range  = (32'(r_idx) < N_ENDPOINTS);
    w_old_entry = '0;
    for (int i = 0; i < N_ENDPOINTS; i++) begin
      if (32'(r_idx) == i) w_old_entry = r_slot[i];
    end
    w_new_entry = {r_ep_valid, r_access, r_bound, r_base};

    if (r_op != OP_INV_ALL && !w_in_range)
      w_chk_status = ST_BAD_IDX;
    else if (r_op == OP_WRITE && r_ep_valid && (r_base > r_bound))
      w_chk_status = ST_BAD_RANGE;
    else
      w_chk_status = ST_OK;

    // Response data: the entry after the command; the untouched entry on error.
    w_after_entry = w_old_entry;
    if (r_status == ST_OK) begin
      case (r_op)
        OP_WRITE:   w_after_entry = w_new_entry;
        OP_INV:     w_after_entry[VBIT] = 1'b0;
        OP_INV_ALL: w_after_entry = '0;
        default:    ;
      endcase
    end
  end

`ifdef EP_PROG_OVERLAP_CHECK_EN
  logic [SJ_W-1:0] r_scan_j;
  logic [EP_W-1:0] w_scan_entry;
  logic            w_scan_hit;
  logic            w_scan_last;

  always_comb begin
    w_scan_entry = '0;
    for (int i = 0; i < N_ENDPOINTS; i++) begin
      if (32'(r_scan_j) == i) w_scan_entry = r_slot[i];
    end
    w_scan_hit  = w_scan_entry[VBIT] && (32'(r_scan_j) != 32'(r_idx)) &&
                  (r_base <= w_scan_entry[95:48]) && (w_scan_entry[47:0] <= r_bound);
    w_scan_last = (32'(r_scan_j) == N_ENDPOINTS - 1);
  end
`endif

  // State register
  always_ff @(posedge aclk) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (s_cmd_valid && s_cmd_ready) w_state_next = S_CHECK;
      S_CHECK: begin
        w_state_next = S_APPLY;
`ifdef EP_PROG_OVERLAP_CHECK_EN
        if (w_chk_status == ST_OK && r_op == OP_WRITE && r_ep_valid) w_state_next = S_SCAN;
`endif
      end
`ifdef EP_PROG_OVERLAP_CHECK_EN
      S_SCAN:  if (w_scan_last) w_state_next = S_APPLY;
`endif
      S_APPLY: w_state_next = S_RESP;
      S_RESP:  if (m_rsp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    s_cmd_ready = (r_state == S_IDLE) && !areset;
    m_rsp_valid = (r_state == S_RESP);
  end

  // Datapath: command latch, status, table update, response registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_op        <= '0;
      r_idx       <= '0;
      r_base      <= '0;
      r_bound     <= '0;
      r_access    <= '0;
      r_ep_valid  <= 1'b0;
      r_status    <= ST_OK;
      r_rsp_data  <= '0;
      r_ep_update <= 1'b0;
      for (int i = 0; i < N_ENDPOINTS; i++) r_slot[i] <= '0;
`ifdef EP_PROG_OVERLAP_CHECK_EN
      r_scan_j    <= '0;
`endif
    end else begin
      r_ep_update <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (s_cmd_valid && s_cmd_ready) begin
            r_op       <= s_cmd_op;
            r_idx      <= s_cmd_idx;
            r_base     <= s_cmd_base;
            r_bound    <= s_cmd_bound;
            r_access   <= s_cmd_access;
            r_ep_valid <= s_cmd_ep_valid;
          end
        end
        S_CHECK: begin
          r_status <= w_chk_status;
`ifdef EP_PROG_OVERLAP_CHECK_EN
          r_scan_j <= '0;
`endif
        end
`ifdef EP_PROG_OVERLAP_CHECK_EN
        // Always walks every slot so latency does not depend on table contents.
        S_SCAN: begin
          if (w_scan_hit) r_status <= ST_OVERLAP;
          r_scan_j <= r_scan_j + 1'b1;
        end
`endif
        S_APPLY: begin
          r_rsp_data  <= w_after_entry;
          r_ep_update <= (r_status == ST_OK) && (r_op != OP_READ);
          if (r_status == ST_OK) begin
            for (int i = 0; i < N_ENDPOINTS; i++) begin
              if (r_op == OP_WRITE && 32'(r_idx) == i) r_slot[i] <= w_new_entry;
              if (r_op == OP_INV && 32'(r_idx) == i)   r_slot[i][VBIT] <= 1'b0;
              if (r_op == OP_INV_ALL)                  r_slot[i][VBIT] <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign m_rsp_status = r_status;
  assign m_rsp_data   = r_rsp_data;
  assign ep_update    = r_ep_update;

  for (genvar gi = 0; gi < N_ENDPOINTS; gi++) begin : g_pack
    assign ep_ctrl[gi*EP_W +: EP_W] = r_slot[gi];
  end

endmodule
